// File: rtl/bitonic_merge_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bitonic_merge_pipe
// Description : Fully pipelined bitonic merge for one block size. The merge is
//               split into log2(BLOCK) compare-exchange substages, and each
//               substage is registered. Each block's sort direction alternates,
//               and the whole vector can be flipped per transaction. The
//               input and output use a valid/ready handshake with full
//               backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module bitonic_merge_pipe #(
  parameter int WIDTH  = 8,      // element width in bits
  parameter int INDEX  = 8,      // elements per vector, power of two >= 2
  parameter int BLOCK  = INDEX,  // merge block size, power of two, 2..INDEX
  parameter int SIGNED = 0       // 1 = two's-complement compare
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_descend,
  input  logic [0:INDEX-1][WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_descend,
  output logic [0:INDEX-1][WIDTH-1:0] out_data,
  output logic                        busy
);

  // Number of substages. The guard keeps the arrays legal if BLOCK is set
  // below 2 by mistake.
  localparam int S  = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  // Index widths, so that loop variables used as array indices are sized.
  localparam int IW = $clog2(INDEX);
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int RW = $clog2(S + 1);

  typedef logic [0:INDEX-1][WIDTH-1:0] vec_t;

  // Element ordering. It is signed or unsigned, as set by the SIGNED parameter.
  function automatic logic elem_gt(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    if (SIGNED != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // One compare-exchange layer at distance d. Each position p with (p & d) == 0
  // is paired with p+d.
  // The direction of a pair follows the parity of its block, flipped by desc.
  // Equal elements are never swapped. Elements are only moved, so there is no
  // width growth.
  function automatic vec_t cmp_exchange(input vec_t v, input logic desc,
                                        input int d);
    vec_t           r;
    logic           asc;
    logic           swap;
    logic [IW-1:0]  ip;
    logic [IW-1:0]  iq;
    r = v;
    for (int p = 0; p < INDEX; p++) begin
      if ((p & d) == 0) begin
        ip   = IW'(p);
        iq   = IW'(p + d);
        asc  = ((((p / BLOCK) % 2) == 0) ? 1'b1 : 1'b0) ^ desc;
        swap = asc ? elem_gt(v[ip], v[iq]) : elem_gt(v[iq], v[ip]);
        if (swap) begin
          r[ip] = v[iq];
          r[iq] = v[ip];
        end
      end
    end
    return r;
  endfunction

  // Per-substage register sets and their next-state values.
  vec_t           data_q  [S];
  vec_t           data_d  [S];
  logic [S-1:0]   desc_q;
  logic [S-1:0]   desc_d;
  logic [S-1:0]   v_q;
  logic [S-1:0]   v_d;

  // Values offered to each substage by the stage behind it.
  vec_t           up_data [S];
  logic [S-1:0]   up_desc;
  logic [S-1:0]   up_v;

  // Ready chain. rdy[s] is set when substage s or any stage ahead of it has a
  // free slot, or when the output drains this cycle. The result is computed
  // as a running OR, so the chain does not feed back into itself.
  logic [S:0]     rdy;

  // Ready chain from the output back to the input. in_valid is not used here.
  always_comb begin
    logic acc;
    acc         = out_ready;
    rdy         = '0;
    rdy[RW'(S)] = out_ready;
    for (int s = S - 1; s >= 0; s--) begin
      acc         = acc | ~v_q[SW'(s)];
      rdy[RW'(s)] = acc;
    end
  end

  // Select what each substage would load: the input port for substage 0, and
  // the previous substage's registers for the others.
  always_comb begin
    up_data[0] = in_data;
    up_desc[0] = in_descend;
    up_v[0]    = in_valid;
    for (int s = 1; s < S; s++) begin
      up_data[SW'(s)] = data_q[SW'(s - 1)];
      up_desc[SW'(s)] = desc_q[SW'(s - 1)];
      up_v[SW'(s)]    = v_q[SW'(s - 1)];
    end
  end

  // Next state. When ready, a substage loads the compare-exchanged upstream
  // vector. Otherwise it holds data, mode and valid, so a stalled vector
  // stays stable.
  always_comb begin
    data_d = data_q;
    desc_d = desc_q;
    v_d    = v_q;
    for (int s = 0; s < S; s++) begin
      if (rdy[RW'(s)]) begin
        data_d[SW'(s)] = cmp_exchange(up_data[SW'(s)], up_desc[SW'(s)],
                                      BLOCK >> (s + 1));
        desc_d[SW'(s)] = up_desc[SW'(s)];
        v_d[SW'(s)]    = up_v[SW'(s)];
      end
    end
  end

  // Substage registers. Reset clears every substage, which discards any
  // vectors in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < S; s++) begin
        data_q[SW'(s)] <= '0;
      end
      desc_q <= '0;
      v_q    <= '0;
    end else begin
      data_q <= data_d;
      desc_q <= desc_d;
      v_q    <= v_d;
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = v_q[SW'(S - 1)];
  assign out_data    = data_q[SW'(S - 1)];
  assign out_descend = desc_q[SW'(S - 1)];
  assign busy        = |v_q;

endmodule
`default_nettype wire

// File: doc/bitonic_merge_pipe.md
# bitonic_merge_pipe

Parameterised, fully pipelined bitonic merge network that generalises the fixed 32/64 compare-exchange step of the sorter. It applies a complete merge for one block size: log2(BLOCK) compare-exchange substages, each registered, with alternating per-block direction and a per-transaction ascending/descending mode. It has a valid/ready handshake on both sides with full backpressure. Instances are chained in the sort datapath, one per merge phase (BLOCK = 2, 4, …, INDEX).

## Interface
- width, 8: element width in bits.
- index, 8: elements per vector; power of two, ≥2.
- BLOCK, index: merge block size; power of two, 2 ≤ BLOCK ≤ index.
- SIGNED, 0: 1 = two's-complement compare, 0 = unsigned compare.

- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector present.
- in_ready  out  1  block accepts the input vector this cycle.
- in_descend  in  1  0 = even blocks ascending, 1 = even blocks descending; sampled with the data.
- in_data  in  [width-1:0] x [0:index-1]  input vector; each BLOCK group must be bitonic.
- out_valid  out  1  output vector present.
- out_ready  in  1  downstream accepts the output vector.
- out_descend  out  1  mode bit carried with the vector.
- out_data  out  [width-1:0] x [0:index-1]  merged vector.
- busy  out  1  OR of all substage valid bits.

## Operation
- S = log2(BLOCK) substages, numbered s = 0…S-1. Substage s uses compare distance d = BLOCK >> (s+1).
- Each substage holds a register set: data[0:index-1], descend, and valid v[s].
- Compare pairs: positions p and p+d for every p with (p & d) == 0.
- Pair direction: asc = ((p / BLOCK) even) XOR descend.
  - asc: position p gets min, position p+d gets max.
  - not asc: position p gets max, position p+d gets min.
- Equal values are not swapped. Compares are signed or unsigned per SIGNED. Elements are moved, never modified, so there is no width growth.
- Handshake:
  - Substage s may load when !v[s] or its contents leave in the same cycle.
  - rdy[S] = out_ready; rdy[s] = !v[s] || rdy[s+1]; in_ready = rdy[0]. This is a combinational ready chain, and in_ready does not depend on in_valid.
  - A transfer occurs when valid && ready. Substage s loads from substage s-1 (or from the input for s = 0) when rdy[s] is high.
  - v[s] next = upstream valid when rdy[s], otherwise it holds.
- A stalled substage holds data, descend and valid stable; no bubble is inserted while the stage ahead is full.
- out_valid = v[S-1]; out_data and out_descend come from substage S-1 registers. There is no combinational path from in_data to out_data.
- Reset: all v[s] = 0, all data registers = 0, all descend registers = 0. Any in-flight vectors are discarded, including on reset mid-stream. in_valid is ignored during reset.

## Timing
- Latency: a vector accepted at edge N appears with out_valid = 1 after edge N+S-1, i.e. S cycles through registers. BLOCK = 8 gives S = 3.
- Throughput: one vector per cycle while out_ready = 1.
- Capacity: S vectors.
  - With out_ready held 0 from empty, exactly S vectors are accepted, then in_ready = 0.
  - One out_ready pulse frees one slot, and in_ready rises in that same cycle.
- Simultaneous events: in the same cycle as an output transfer, a full pipeline accepts a new input, so occupancy is unchanged.
- Output values immediately after reset: out_valid = 0, out_descend = 0, out_data all 0, busy = 0. in_ready = 1 in the first cycle after reset.
- out_data and out_descend are stable while out_valid && !out_ready.

## Test plan
- index = 8, BLOCK = 8, descend = 0: input [1,3,5,7,8,6,4,2] → [1,2,3,4,5,6,7,8] with out_valid high 3 cycles after acceptance. Repeat with descend = 1 → [8,7,6,5,4,3,2,1].
- index = 8, BLOCK = 4, descend = 0: input [1,4,3,2,8,5,6,7] → [1,2,3,4,8,7,6,5], latency 2.
- Backpressure, BLOCK = 8, out_ready = 0: drive 5 consecutive valid vectors.
  - Required: exactly 3 accepted and in_ready = 0 afterwards.
  - Release out_ready: all 5 outputs emerge in order, with no loss or duplication.
- Random stall, SIGNED = 1, width = 8: 1000 random bitonic vectors (values −128…127) with random in_valid and out_ready. Every output must match a reference sort in the mode given by its descend bit, and output order must equal input order.
- Ties and reset: input [5,5,5,5,5,5,5,5] → the same vector unchanged. Then assert rst for 1 cycle with 2 vectors in flight → out_valid = 0 and busy = 0 on the next cycle, and no stale vector is emitted afterwards.
